// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline encodings for the stage boundary registers: NOP payload
// values, stall polarity, write-enable polarity and the per-edge action type.
package pipe_stage_reg_pkg;

  localparam logic [7:0]  EXE_NOP_OP    = 8'b0000_0000;
  localparam logic [2:0]  EXE_RES_NOP   = 3'b000;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;
  localparam logic        STOP          = 1'b1;
  localparam logic        NO_STOP       = 1'b0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_CAPTURE = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_FLUSH   = 2'd3
  } stage_act_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, and
// clears synchronously (clear wins over inc).
module pipe_stage_reg_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register between two adjacent core stages, driven by the
// controller stall vector, with flush, bubble insertion and occupancy counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int STALL_W  = 6,
  parameter int STAGE    = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [ALUOP_W-1:0]  in_aluop,
  input  logic [ALUSEL_W-1:0] in_alusel,
  input  logic [DATA_W-1:0]   in_reg1,
  input  logic [DATA_W-1:0]   in_reg2,
  input  logic [ADDR_W-1:0]   in_wd,
  input  logic                in_wreg,
  input  logic [DATA_W-1:0]   in_link_addr,
  input  logic                in_is_in_delayslot,
  input  logic                in_next_in_delayslot,
  output logic                out_valid,
  output logic [ALUOP_W-1:0]  out_aluop,
  output logic [ALUSEL_W-1:0] out_alusel,
  output logic [DATA_W-1:0]   out_reg1,
  output logic [DATA_W-1:0]   out_reg2,
  output logic [ADDR_W-1:0]   out_wd,
  output logic                out_wreg,
  output logic [DATA_W-1:0]   out_link_addr,
  output logic                out_is_in_delayslot,
  output logic                next_in_delayslot_o,
  output logic [CNT_W-1:0]    bubble_cnt,
  output logic [CNT_W-1:0]    hold_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam int PAY_W = ALUOP_W + ALUSEL_W + 3 * DATA_W + ADDR_W + 2;

  logic up;
  logic dn;
  logic unused_stall;

  // The last stage has no downstream stall bit, so a stall there is a bubble.
  if (STAGE >= STALL_W) begin : g_bad_stage
    $fatal(1, "pipe_stage_reg: STAGE (%0d) must be below STALL_W (%0d)", STAGE, STALL_W);
  end else if (STAGE == STALL_W - 1) begin : g_last_stage
    assign up = (stall[STAGE] == STOP);
    assign dn = NO_STOP;
  end else begin : g_mid_stage
    assign up = (stall[STAGE] == STOP);
    assign dn = (stall[STAGE+1] == STOP);
  end

  assign unused_stall = ^stall;

  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] pay_nop;
  logic [PAY_W-1:0] pay_d;
  logic [PAY_W-1:0] pay_q;
  logic             valid_d;
  logic             valid_q;
  logic             next_ds_d;
  logic             next_ds_q;
  stage_act_e       act;

  assign pay_in  = {in_aluop, in_alusel, in_reg1, in_reg2, in_wd, in_wreg,
                    in_link_addr, in_is_in_delayslot};
  assign pay_nop = {ALUOP_W'(EXE_NOP_OP), ALUSEL_W'(EXE_RES_NOP),
                    DATA_W'(ZERO_WORD), DATA_W'(ZERO_WORD),
                    ADDR_W'(NOP_REG_ADDR), WRITE_DISABLE,
                    DATA_W'(ZERO_WORD), 1'b0};

  always_comb begin
    act = ACT_HOLD;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (up && !dn) begin
      act = ACT_BUBBLE;
    end else if (!up) begin
      act = ACT_CAPTURE;
    end
  end

  // A bubble keeps next_ds so a stalled branch still marks its delay slot.
  always_comb begin
    pay_d     = pay_q;
    valid_d   = valid_q;
    next_ds_d = next_ds_q;
    unique case (act)
      ACT_FLUSH: begin
        pay_d     = pay_nop;
        valid_d   = 1'b0;
        next_ds_d = 1'b0;
      end
      ACT_BUBBLE: begin
        pay_d   = pay_nop;
        valid_d = 1'b0;
      end
      ACT_CAPTURE: begin
        pay_d     = pay_in;
        valid_d   = in_valid;
        next_ds_d = in_next_in_delayslot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pay_q     <= '0;
      valid_q   <= 1'b0;
      next_ds_q <= 1'b0;
    end else begin
      pay_q     <= pay_d;
      valid_q   <= valid_d;
      next_ds_q <= next_ds_d;
    end
  end

  assign {out_aluop, out_alusel, out_reg1, out_reg2, out_wd, out_wreg,
          out_link_addr, out_is_in_delayslot} = pay_q;
  assign out_valid           = valid_q;
  assign next_in_delayslot_o = next_ds_q;

  pipe_stage_reg_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (act == ACT_BUBBLE),
    .count (bubble_cnt)
  );

  pipe_stage_reg_sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (act == ACT_HOLD),
    .count (hold_cnt)
  );

  pipe_stage_reg_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (act == ACT_FLUSH),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a mid-pipe instance, a 2-bit-counter instance and a
// last-stage instance share one stimulus stream with hand-computed results.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid;
  logic [7:0]  in_aluop;
  logic [2:0]  in_alusel;
  logic [31:0] in_reg1;
  logic [31:0] in_reg2;
  logic [4:0]  in_wd;
  logic        in_wreg;
  logic [31:0] in_link_addr;
  logic        in_is_ds;
  logic        in_next_ds;

  logic        m_valid, m_wreg, m_is_ds, m_next_ds;
  logic [7:0]  m_aluop;
  logic [2:0]  m_alusel;
  logic [31:0] m_reg1, m_reg2, m_link;
  logic [4:0]  m_wd;
  logic [15:0] m_bub, m_hold, m_flush;

  logic        s_valid, s_wreg, s_is_ds, s_next_ds;
  logic [7:0]  s_aluop;
  logic [2:0]  s_alusel;
  logic [31:0] s_reg1, s_reg2, s_link;
  logic [4:0]  s_wd;
  logic [1:0]  s_bub, s_hold, s_flush;

  logic        l_valid, l_wreg, l_is_ds, l_next_ds;
  logic [7:0]  l_aluop;
  logic [2:0]  l_alusel;
  logic [31:0] l_reg1, l_reg2, l_link;
  logic [4:0]  l_wd;
  logic [15:0] l_bub, l_hold, l_flush;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.STAGE(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_aluop(in_aluop), .in_alusel(in_alusel),
    .in_reg1(in_reg1), .in_reg2(in_reg2), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_link_addr(in_link_addr), .in_is_in_delayslot(in_is_ds),
    .in_next_in_delayslot(in_next_ds),
    .out_valid(m_valid), .out_aluop(m_aluop), .out_alusel(m_alusel),
    .out_reg1(m_reg1), .out_reg2(m_reg2), .out_wd(m_wd), .out_wreg(m_wreg),
    .out_link_addr(m_link), .out_is_in_delayslot(m_is_ds),
    .next_in_delayslot_o(m_next_ds),
    .bubble_cnt(m_bub), .hold_cnt(m_hold), .flush_cnt(m_flush)
  );

  pipe_stage_reg #(.STAGE(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_aluop(in_aluop), .in_alusel(in_alusel),
    .in_reg1(in_reg1), .in_reg2(in_reg2), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_link_addr(in_link_addr), .in_is_in_delayslot(in_is_ds),
    .in_next_in_delayslot(in_next_ds),
    .out_valid(s_valid), .out_aluop(s_aluop), .out_alusel(s_alusel),
    .out_reg1(s_reg1), .out_reg2(s_reg2), .out_wd(s_wd), .out_wreg(s_wreg),
    .out_link_addr(s_link), .out_is_in_delayslot(s_is_ds),
    .next_in_delayslot_o(s_next_ds),
    .bubble_cnt(s_bub), .hold_cnt(s_hold), .flush_cnt(s_flush)
  );

  pipe_stage_reg #(.STAGE(5), .CNT_W(16)) u_last (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_aluop(in_aluop), .in_alusel(in_alusel),
    .in_reg1(in_reg1), .in_reg2(in_reg2), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_link_addr(in_link_addr), .in_is_in_delayslot(in_is_ds),
    .in_next_in_delayslot(in_next_ds),
    .out_valid(l_valid), .out_aluop(l_aluop), .out_alusel(l_alusel),
    .out_reg1(l_reg1), .out_reg2(l_reg2), .out_wd(l_wd), .out_wreg(l_wreg),
    .out_link_addr(l_link), .out_is_in_delayslot(l_is_ds),
    .next_in_delayslot_o(l_next_ds),
    .bubble_cnt(l_bub), .hold_cnt(l_hold), .flush_cnt(l_flush)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    stall        = 6'($urandom);
    flush        = 1'($urandom);
    in_valid     = 1'($urandom);
    in_aluop     = 8'($urandom);
    in_alusel    = 3'($urandom);
    in_reg1      = $urandom;
    in_reg2      = $urandom;
    in_wd        = 5'($urandom);
    in_wreg      = 1'($urandom);
    in_link_addr = $urandom;
    in_is_ds     = 1'($urandom);
    in_next_ds   = 1'($urandom);
    tick();
    tick();

    // Reset state
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_aluop", 64'(m_aluop), 64'd0);
    chk("rst_alusel", 64'(m_alusel), 64'd0);
    chk("rst_reg1", 64'(m_reg1), 64'd0);
    chk("rst_reg2", 64'(m_reg2), 64'd0);
    chk("rst_wd", 64'(m_wd), 64'd0);
    chk("rst_wreg", 64'(m_wreg), 64'd0);
    chk("rst_link", 64'(m_link), 64'd0);
    chk("rst_is_ds", 64'(m_is_ds), 64'd0);
    chk("rst_next_ds", 64'(m_next_ds), 64'd0);
    chk("rst_cnts", {16'd0, m_bub, m_hold, m_flush}, 64'd0);
    chk("rst_last_cnts", {16'd0, l_bub, l_hold, l_flush}, 64'd0);

    // First capture; outputs must not move before the edge
    rst          = 1'b0;
    stall        = 6'b000000;
    flush        = 1'b0;
    in_valid     = 1'b1;
    in_aluop     = 8'h21;
    in_alusel    = 3'b010;
    in_reg1      = 32'h0000_1234;
    in_reg2      = 32'h0000_abcd;
    in_wd        = 5'd3;
    in_wreg      = 1'b1;
    in_link_addr = 32'h0000_0100;
    in_is_ds     = 1'b0;
    in_next_ds   = 1'b1;
    #1;
    chk("no_comb_path", {55'd0, m_valid, m_aluop}, 64'd0);
    tick();
    chk("cap_valid", 64'(m_valid), 64'd1);
    chk("cap_aluop", 64'(m_aluop), 64'h21);
    chk("cap_alusel", 64'(m_alusel), 64'd2);
    chk("cap_reg1", 64'(m_reg1), 64'h1234);
    chk("cap_reg2", 64'(m_reg2), 64'habcd);
    chk("cap_wd_wreg", {58'd0, m_wd, m_wreg}, {58'd0, 5'd3, 1'b1});
    chk("cap_link", 64'(m_link), 64'h100);
    chk("cap_next_ds", 64'(m_next_ds), 64'd1);

    // Bubble: up=1, dn=0 at stage 2; stage 5 still captures
    stall = 6'b000111;
    tick();
    chk("bub_aluop", 64'(m_aluop), 64'd0);
    chk("bub_reg1", 64'(m_reg1), 64'd0);
    chk("bub_wreg", 64'(m_wreg), 64'd0);
    chk("bub_valid", 64'(m_valid), 64'd0);
    chk("bub_next_ds_kept", 64'(m_next_ds), 64'd1);
    chk("bub_cnt", 64'(m_bub), 64'd1);
    chk("bub_last_captures", {55'd0, l_valid, l_aluop}, {55'd0, 1'b1, 8'h21});

    // Recapture, then hold for 3 cycles while inputs change
    stall    = 6'b000000;
    in_aluop = 8'h2a;
    in_reg1  = 32'h0000_5555;
    tick();
    chk("recap_aluop", 64'(m_aluop), 64'h2a);
    stall    = 6'b001111;
    in_aluop = 8'h33;
    in_reg1  = 32'h0000_9999;
    tick();
    tick();
    tick();
    chk("hold_aluop", 64'(m_aluop), 64'h2a);
    chk("hold_reg1", 64'(m_reg1), 64'h5555);
    chk("hold_valid", 64'(m_valid), 64'd1);
    chk("hold_cnt", 64'(m_hold), 64'd3);
    chk("hold_bub_unchanged", 64'(m_bub), 64'd1);
    chk("hold_sat_exact", 64'(s_hold), 64'd3);
    chk("hold_last_captures", 64'(l_aluop), 64'h33);

    // Flush beats a coincident capture
    stall      = 6'b000000;
    flush      = 1'b1;
    in_wreg    = 1'b1;
    in_wd      = 5'd7;
    in_is_ds   = 1'b1;
    in_next_ds = 1'b1;
    tick();
    chk("fl_wreg", 64'(m_wreg), 64'd0);
    chk("fl_wd", 64'(m_wd), 64'd0);
    chk("fl_aluop", 64'(m_aluop), 64'd0);
    chk("fl_is_ds", 64'(m_is_ds), 64'd0);
    chk("fl_next_ds", 64'(m_next_ds), 64'd0);
    chk("fl_valid", 64'(m_valid), 64'd0);
    chk("fl_cnt", 64'(m_flush), 64'd1);
    chk("fl_last_cnt", 64'(l_flush), 64'd1);

    flush = 1'b0;
    tick();
    chk("post_fl_wd_wreg", {58'd0, m_wd, m_wreg}, {58'd0, 5'd7, 1'b1});
    chk("post_fl_valid", 64'(m_valid), 64'd1);
    chk("post_fl_is_ds", 64'(m_is_ds), 64'd1);
    chk("post_fl_aluop", 64'(m_aluop), 64'h33);

    // Flush while held discards the held instruction
    stall = 6'b001111;
    flush = 1'b1;
    tick();
    chk("flhold_valid", 64'(m_valid), 64'd0);
    chk("flhold_wd", 64'(m_wd), 64'd0);
    chk("flhold_cnt", 64'(m_flush), 64'd2);
    chk("flhold_hold_cnt", 64'(m_hold), 64'd3);

    // Five bubbles: 2-bit counter goes 1 -> 3 and sticks
    flush = 1'b0;
    stall = 6'b000111;
    tick();
    tick();
    chk("sat_mid", 64'(s_bub), 64'd3);
    tick();
    tick();
    tick();
    chk("sat_bub", 64'(s_bub), 64'd3);
    chk("sat_ref_bub", 64'(m_bub), 64'd6);
    chk("sat_flush", 64'(s_flush), 64'd2);

    // Last stage: stall bit 5 with no downstream bit is a bubble
    stall = 6'b100000;
    tick();
    chk("last_valid", 64'(l_valid), 64'd0);
    chk("last_aluop", 64'(l_aluop), 64'd0);
    chk("last_bub", 64'(l_bub), 64'd1);
    chk("last_hold", 64'(l_hold), 64'd0);
    chk("last_mid_captures", 64'(m_valid), 64'd1);

    // Reset mid-stall clears everything, counters not bumped by the rst cycle
    stall = 6'b001111;
    rst   = 1'b1;
    tick();
    chk("rst2_valid", 64'(m_valid), 64'd0);
    chk("rst2_aluop", 64'(m_aluop), 64'd0);
    chk("rst2_next_ds", 64'(m_next_ds), 64'd0);
    chk("rst2_cnts", {16'd0, m_bub, m_hold, m_flush}, 64'd0);
    chk("rst2_sat_cnts", {58'd0, s_bub, s_hold, s_flush}, 64'd0);

    rst      = 1'b0;
    stall    = 6'b000000;
    in_aluop = 8'h44;
    in_valid = 1'b1;
    tick();
    chk("resume_aluop", 64'(m_aluop), 64'h44);
    chk("resume_valid", 64'(m_valid), 64'd1);
    chk("resume_cnts", {16'd0, m_bub, m_hold, m_flush}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
